// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter (dmem_arbiter, dmem_arb_pick).
package dmem_arbiter_pkg;

  localparam int unsigned WD_SIZE      = 32;
  localparam int unsigned ARB_CNT_SIZE = 4;
  localparam int unsigned PERF_SIZE    = 32;

  localparam logic [ARB_CNT_SIZE-1:0] ARB_CNT_MAX = '1;

  typedef enum logic {
    ARB_IDLE,
    ARB_RD_BUSY
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_MEM,
    ARB_OWNER_AUX
  } arb_owner_e;

  // One requester's access fields, muxed onto the dmem port on grant.
  typedef struct packed {
    logic               we;
    logic [WD_SIZE-1:0] addr;
    logic [WD_SIZE-1:0] wr_data;
    logic [WD_SIZE-1:0] wr_keep;
  } arb_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Priority pick between MEM and aux with a saturating starvation counter for aux.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AUX_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic eligible_i,
  input  logic mem_req_i,
  input  logic aux_req_i,
  input  logic mem_blocked_i,
  output logic mem_gnt_o,
  output logic aux_gnt_o
);

  logic [ARB_CNT_SIZE-1:0] starve_q, starve_d;
  logic                    aux_wins;

  always_comb begin
    aux_wins  = aux_req_i & (~mem_req_i | mem_blocked_i |
                             (starve_q >= ARB_CNT_SIZE'(AUX_MAX_WAIT)));
    aux_gnt_o = eligible_i & aux_wins;
    mem_gnt_o = eligible_i & mem_req_i & ~mem_blocked_i & ~aux_wins;

    starve_d = starve_q;
    if (!aux_req_i || aux_gnt_o) begin
      starve_d = '0;
    end else if (eligible_i && (starve_q != ARB_CNT_MAX)) begin
      starve_d = starve_q + ARB_CNT_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port dmem: fixed-latency reads, posted writes, pipeline stall.
// Optional DMEM_ARB_PERF_EN adds saturating stall-cycle and aux-grant counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned AUX_MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_req_i,
  input  logic               mem_we_i,
  input  logic [WD_SIZE-1:0] mem_addr_i,
  input  logic [WD_SIZE-1:0] mem_wr_data_i,
  input  logic [WD_SIZE-1:0] mem_wr_keep_i,
  output logic               mem_gnt_o,
  output logic               mem_rvalid_o,
  output logic [WD_SIZE-1:0] mem_rdata_o,
  input  logic               aux_req_i,
  input  logic               aux_we_i,
  input  logic [WD_SIZE-1:0] aux_addr_i,
  input  logic [WD_SIZE-1:0] aux_wr_data_i,
  input  logic [WD_SIZE-1:0] aux_wr_keep_i,
  output logic               aux_gnt_o,
  output logic               aux_rvalid_o,
  output logic [WD_SIZE-1:0] aux_rdata_o,
  output logic               dmem_op_en_o,
  output logic               dmem_rd_wr_o,
  output logic [WD_SIZE-1:0] dmem_addr_o,
  output logic [WD_SIZE-1:0] dmem_wr_data_o,
  output logic [WD_SIZE-1:0] dmem_wr_keep_o,
  input  logic [WD_SIZE-1:0] dmem_rd_data_i,
  output logic               stall_proc_o
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [PERF_SIZE-1:0] perf_stall_cnt_o,
  output logic [PERF_SIZE-1:0] perf_aux_grant_cnt_o
`endif
);

  arb_state_e              state_q, state_d;
  arb_owner_e              owner_q, owner_d;
  logic [ARB_CNT_SIZE-1:0] cnt_q, cnt_d;
  logic                    final_busy, eligible, mem_blocked;
  logic                    gnt_mem, gnt_aux;
  arb_req_t                mem_fields, aux_fields, sel_fields;

  // The stalled MEM stage still presents the old load in its own final busy cycle.
  always_comb begin
    final_busy  = (state_q == ARB_RD_BUSY) && (cnt_q == ARB_CNT_SIZE'(1));
    eligible    = !reset && ((state_q == ARB_IDLE) || final_busy);
    mem_blocked = final_busy && (owner_q == ARB_OWNER_MEM);
  end

  dmem_arb_pick #(
    .AUX_MAX_WAIT(AUX_MAX_WAIT)
  ) u_pick (
    .clk          (clk),
    .reset        (reset),
    .eligible_i   (eligible),
    .mem_req_i    (mem_req_i),
    .aux_req_i    (aux_req_i),
    .mem_blocked_i(mem_blocked),
    .mem_gnt_o    (gnt_mem),
    .aux_gnt_o    (gnt_aux)
  );

  always_comb begin
    mem_fields = '{we: mem_we_i, addr: mem_addr_i, wr_data: mem_wr_data_i, wr_keep: mem_wr_keep_i};
    aux_fields = '{we: aux_we_i, addr: aux_addr_i, wr_data: aux_wr_data_i, wr_keep: aux_wr_keep_i};
    sel_fields = gnt_aux ? aux_fields : mem_fields;
  end

  // Next-state and outputs.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;

    mem_gnt_o      = gnt_mem;
    aux_gnt_o      = gnt_aux;
    dmem_op_en_o   = gnt_mem | gnt_aux;
    dmem_rd_wr_o   = sel_fields.we;
    dmem_addr_o    = sel_fields.addr;
    dmem_wr_data_o = sel_fields.wr_data;
    dmem_wr_keep_o = sel_fields.wr_keep;
    mem_rvalid_o   = !reset && final_busy && (owner_q == ARB_OWNER_MEM);
    aux_rvalid_o   = !reset && final_busy && (owner_q == ARB_OWNER_AUX);
    mem_rdata_o    = dmem_rd_data_i;
    aux_rdata_o    = dmem_rd_data_i;

    // A granted MEM load also stalls: its data is not back until MEM_LATENCY cycles later.
    stall_proc_o = !reset &&
                   ((mem_req_i && !gnt_mem && !mem_rvalid_o) ||
                    (gnt_mem && !mem_we_i) ||
                    ((state_q == ARB_RD_BUSY) && (owner_q == ARB_OWNER_MEM) && !mem_rvalid_o));

    if (state_q == ARB_RD_BUSY) begin
      cnt_d = cnt_q - ARB_CNT_SIZE'(1);
      if (final_busy) begin
        state_d = ARB_IDLE;
      end
    end

    if ((gnt_mem || gnt_aux) && !sel_fields.we) begin
      state_d = ARB_RD_BUSY;
      owner_d = gnt_aux ? ARB_OWNER_AUX : ARB_OWNER_MEM;
      cnt_d   = ARB_CNT_SIZE'(MEM_LATENCY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWNER_MEM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [PERF_SIZE-1:0] perf_stall_q, perf_aux_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_aux_q   <= '0;
    end else begin
      if (stall_proc_o && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + PERF_SIZE'(1);
      end
      if (gnt_aux && (perf_aux_q != '1)) begin
        perf_aux_q <= perf_aux_q + PERF_SIZE'(1);
      end
    end
  end

  assign perf_stall_cnt_o     = perf_stall_q;
  assign perf_aux_grant_cnt_o = perf_aux_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants/read data, a monitor checks every cycle.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned LAT = 2;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] keep;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, aux_req, aux_we;
  logic [31:0] mem_addr, mem_wd, mem_keep, aux_addr, aux_wd, aux_keep;
  logic        mem_gnt_o, mem_rvalid_o, aux_gnt_o, aux_rvalid_o;
  logic [31:0] mem_rdata_o, aux_rdata_o;
  logic        dmem_op_en_o, dmem_rd_wr_o, stall_proc_o;
  logic [31:0] dmem_addr_o, dmem_wr_data_o, dmem_wr_keep_o, dmem_rd_data_i;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt_o, perf_aux_grant_cnt_o;
`endif

  dmem_arbiter #(.MEM_LATENCY(LAT), .AUX_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wr_data_i(mem_wd), .mem_wr_keep_i(mem_keep),
    .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
    .aux_req_i(aux_req), .aux_we_i(aux_we), .aux_addr_i(aux_addr),
    .aux_wr_data_i(aux_wd), .aux_wr_keep_i(aux_keep),
    .aux_gnt_o(aux_gnt_o), .aux_rvalid_o(aux_rvalid_o), .aux_rdata_o(aux_rdata_o),
    .dmem_op_en_o(dmem_op_en_o), .dmem_rd_wr_o(dmem_rd_wr_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wr_data_o(dmem_wr_data_o), .dmem_wr_keep_o(dmem_wr_keep_o),
    .dmem_rd_data_i(dmem_rd_data_i), .stall_proc_o(stall_proc_o)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cnt_o(perf_stall_cnt_o), .perf_aux_grant_cnt_o(perf_aux_grant_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;
  bit   exp_stall [0:2047];
  exp_t q_mg[$], q_ag[$], q_mr[$], q_ar[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input int c, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] k);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.data = d; e.keep = k;
    return e;
  endfunction

  // Memory model: masked writes, reads returned LAT cycles after issue.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    logic [31:0] old;
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= 32'h0;
    if (dmem_op_en_o) begin
      old = mem.exists(dmem_addr_o) ? mem[dmem_addr_o] : 32'h0;
      if (dmem_rd_wr_o) mem[dmem_addr_o] = (old & ~dmem_wr_keep_o) | (dmem_wr_data_o & dmem_wr_keep_o);
      else rd_pipe[0] <= old;
    end
  end
  assign dmem_rd_data_i = rd_pipe[LAT-1];

  // Monitor: any grant/rvalid must match the head of its queue in cycle and contents.
  always @(negedge clk) begin
    logic em, ea, rm, ra;
    exp_t e;
    if (chk_en) begin
      em = (q_mg.size() > 0) && (q_mg[0].cyc == cyc);
      ea = (q_ag.size() > 0) && (q_ag[0].cyc == cyc);
      rm = (q_mr.size() > 0) && (q_mr[0].cyc == cyc);
      ra = (q_ar.size() > 0) && (q_ar[0].cyc == cyc);
      chk("mem_gnt", 32'(mem_gnt_o), 32'(em));
      chk("aux_gnt", 32'(aux_gnt_o), 32'(ea));
      chk("op_en", 32'(dmem_op_en_o), 32'(em | ea));
      chk("mem_rvalid", 32'(mem_rvalid_o), 32'(rm));
      chk("aux_rvalid", 32'(aux_rvalid_o), 32'(ra));
      chk("stall", 32'(stall_proc_o), 32'(exp_stall[cyc]));
      if (em || ea) begin
        e = em ? q_mg.pop_front() : q_ag.pop_front();
        chk("rd_wr", 32'(dmem_rd_wr_o), 32'(e.we));
        chk("addr", dmem_addr_o, e.addr);
        if (e.we) begin
          chk("wr_data", dmem_wr_data_o, e.data);
          chk("wr_keep", dmem_wr_keep_o, e.keep);
        end
      end
      if (rm) begin
        e = q_mr.pop_front();
        chk("mem_rdata", mem_rdata_o, e.data);
      end
      if (ra) begin
        e = q_ar.pop_front();
        chk("aux_rdata", aux_rdata_o, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int k;
    reset = 1'b1;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wd = 0; mem_keep = 0;
    aux_req = 0; aux_we = 0; aux_addr = 0; aux_wd = 0; aux_keep = 0;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'h0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h104] = 32'hCAFEBA00;
    mem[32'h108] = 32'h55AA55AA;

    step(); chk_en = 1'b1;
    step(); reset = 1'b0;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_rst", perf_stall_cnt_o, 32'h0);
    chk("perf_aux_rst", perf_aux_grant_cnt_o, 32'h0);
`endif
    step(); step();

    // Uncontended MEM load
    c = cyc;
    mem_req = 1; mem_we = 0; mem_addr = 32'h100;
    q_mg.push_back(mk(c, 1'b0, 32'h100, 0, 0));
    q_mr.push_back(mk(c + 2, 1'b0, 0, 32'hDEADBEEF, 0));
    exp_stall[c] = 1; exp_stall[c+1] = 1;
    step(); step(); step();
    mem_req = 0;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_1", perf_stall_cnt_o, 32'd2);
`endif
    step();

    // Posted MEM store
    c = cyc;
    mem_req = 1; mem_we = 1; mem_addr = 32'h104; mem_wd = 32'h12; mem_keep = 32'h0000_00FF;
    q_mg.push_back(mk(c, 1'b1, 32'h104, 32'h12, 32'h0000_00FF));
    step();
    mem_req = 0;
    step();

    // Continuous contention with back-to-back writes
    c = cyc;
    aux_req = 1; aux_we = 1; aux_addr = 32'h300; aux_wd = 32'hA5A5A5A5; aux_keep = 32'hFFFF_FFFF;
    q_ag.push_back(mk(c + 4, 1'b1, 32'h300, 32'hA5A5A5A5, 32'hFFFF_FFFF));
    exp_stall[c+4] = 1;
    for (int i = 0; i < 6; i++) begin
      k = (i < 4) ? i : 4;
      mem_req = 1; mem_we = 1; mem_addr = 32'h200 + 32'(4 * k);
      mem_wd = 32'h1000 + 32'(k); mem_keep = 32'hFFFF_FFFF;
      if (i != 4) q_mg.push_back(mk(c + i, 1'b1, mem_addr, mem_wd, mem_keep));
      if (i == 5) aux_req = 0;
      step();
    end
    mem_req = 0;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_aux_3", perf_aux_grant_cnt_o, 32'd1);
`endif
    step();

    // Aux read granted in the final cycle of a MEM load
    c = cyc;
    mem_req = 1; mem_we = 0; mem_addr = 32'h100;
    aux_req = 1; aux_we = 0; aux_addr = 32'h104;
    q_mg.push_back(mk(c, 1'b0, 32'h100, 0, 0));
    q_mr.push_back(mk(c + 2, 1'b0, 0, 32'hDEADBEEF, 0));
    q_ag.push_back(mk(c + 2, 1'b0, 32'h104, 0, 0));
    q_ar.push_back(mk(c + 4, 1'b0, 0, 32'hCAFEBA12, 0));
    exp_stall[c] = 1; exp_stall[c+1] = 1;
    step(); step(); step();
    mem_req = 0; aux_req = 0;
    step(); step(); step();

    // Reset during a MEM read; aux requests through reset
    c = cyc;
    mem_req = 1; mem_we = 0; mem_addr = 32'h108;
    q_mg.push_back(mk(c, 1'b0, 32'h108, 0, 0));
    exp_stall[c] = 1;
    step();
    reset = 1; mem_req = 0;
    aux_req = 1; aux_we = 0; aux_addr = 32'h108;
    step();
    reset = 0;
    q_ag.push_back(mk(c + 2, 1'b0, 32'h108, 0, 0));
    q_ar.push_back(mk(c + 4, 1'b0, 0, 32'h55AA55AA, 0));
    step();
    aux_req = 0;
    step(); step(); step(); step();

    chk_en = 1'b0;
    chk("q_mem_gnt_left", 32'(q_mg.size()), 32'd0);
    chk("q_aux_gnt_left", 32'(q_ag.size()), 32'd0);
    chk("q_mem_rv_left", 32'(q_mr.size()), 32'd0);
    chk("q_aux_rv_left", 32'(q_ar.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
